fmul_rr_scheduler: RTL and testbench
====================================

Name: fmul_rr_scheduler

Overview:
- Shares one pipelined single-to-double float multiplier datapath among NUM_REQ requesters.
- Each requester presents an operand pair on a valid/ready channel. A round-robin arbiter issues at most one pair per cycle into a LATENCY-stage pipeline.
- Products return on a single tagged valid/ready result channel through a credit-protected result FIFO.
- Sits between the compute clients and the multiplier core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 2, register stages between issue and FIFO write (1..4).
- FIFO_DEPTH, 4, result FIFO entries; must be >= LATENCY.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester operand valid.
- req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
- req_a  input  32*NUM_REQ  operand A, IEEE single; slice i belongs to requester i.
- req_b  input  32*NUM_REQ  operand B, IEEE single.
- res_valid  output  1  result FIFO head valid.
- res_ready  input  1  consumer accept.
- res_data  output  64  double-format product.
- res_id  output  clog2(NUM_REQ)  requester index of the product.
- busy  output  1  high when any operation is in flight or buffered.

Behaviour:
- Reset values:
  - req_ready=0, res_valid=0, res_data=0, res_id=0, busy=0.
  - Round-robin pointer=0, in-flight count=0, FIFO empty.
- Reset is asynchronous and may assert mid-operation. All in-flight and buffered results are discarded with no output pulse.
- Credit rule: issue is allowed only when inflight + fifo_count < FIFO_DEPTH. Counts are taken before this cycle's events. The FIFO therefore never overflows and res_ready never stalls the pipeline.
- Arbitration (combinational, same cycle):
  - When credit is available, grant the first requester with req_valid=1 searching from ptr, ptr+1, … modulo NUM_REQ.
  - req_ready[grant]=1; all other bits are 0. With no credit, all bits are 0.
  - A transfer happens when req_valid[i] & req_ready[i].
  - On a transfer, ptr <= grant+1 modulo NUM_REQ. Otherwise ptr holds.
- Datapath, computed on issued operands a and b:
  - If a[30:0]==0 or b[30:0]==0, the result is 64'h0. Sign is also 0.
  - Otherwise:
    - sign = a[31]^b[31].
    - exp11 = a[30:23] + b[30:23] + 769, modulo 2^11.
    - P = {1,a[22:0]} * {1,b[22:0]}, 48 bits.
    - mant52 = {P[45:0], 6'b0}.
    - result = {sign, exp11, mant52}.
  - There is no normalisation and no rounding.
- Pipeline:
  - Latency from issue to FIFO write is exactly LATENCY cycles.
  - The requester id travels with the data.
  - One valid bit per stage; there are no bubbles to squeeze.
- Result FIFO:
  - Write occurs when the last pipeline stage is valid.
  - Read occurs when res_valid & res_ready.
  - Simultaneous read and write keep the count unchanged, including when full or empty.
  - A write to an empty FIFO shows res_valid on the following cycle; there is no fall-through.
  - Pointers wrap modulo FIFO_DEPTH.
- Counters:
  - inflight increments on issue and decrements on FIFO write; both in the same cycle leave it unchanged.
  - busy = (inflight != 0) | (fifo_count != 0).
- Ordering: results leave in issue order.

Optional Feature:
- Macro: FMUL_RR_SCHEDULER_STATS_EN.
- When defined:
  - Adds output grant_cnt, width 16*NUM_REQ: per-requester saturating 16-bit counts of accepted transfers.
  - Adds output stall_cyc, width 16: saturating count of cycles with any req_valid=1 but no credit.
  - Both reset to 0 and hold at 16'hFFFF.
- When undefined: the ports and counters are absent. Core behaviour is identical.

Decomposition:
- Shared package fmul_pkg holds:
  - Constants FP32_EXP_W=8, FP32_MAN_W=23, FP64_EXP_W=11, FP64_MAN_W=52, EXP_REBIAS=769.
  - Typedef fmul_res_t (64-bit).
  - A function computing the datapath result.
- One sub-module, fmul_pipe: datapath plus LATENCY-stage data/id/valid shift registers.
- Arbiter, credit counter and FIFO live in the top.

Test Plan:
- Single op: requester 0 sends a=32'h3F800000, b=32'h3F800000.
  - Expect ready the same cycle.
  - Expect res_valid LATENCY+1 cycles later with res_data=64'h3FF0000000000000, res_id=0.
- Arithmetic: a=32'h40000000, b=32'h40400000 → res_data=64'h4018000000000000.
- Zero operands:
  - a=32'h80000000 with any b → 64'h0.
  - a=32'hC0000000, b=32'h40000000 → sign bit 1, res_data=64'hC010000000000000.
- Round-robin: all four requesters valid continuously with res_ready=1 → grants 0,1,2,3,0,… with one grant per cycle, and res_id follows the same order.
- Back-pressure: res_ready=0 while all requesters are valid.
  - Exactly FIFO_DEPTH transfers are accepted, then req_ready stays 0 and busy=1.
  - Raising res_ready drains results in order, with no loss or duplicates.
- Reset mid-flight: assert rst_n=0 with 3 ops in flight.
  - All outputs return to reset values immediately.
  - After release, the first grant goes to requester 0.

Source files
------------

// File: rtl/fmul_pkg.sv
// rtl/fmul_pkg.sv - shared constants, result type and datapath function for the fmul scheduler
package fmul_pkg;

    localparam int FP32_EXP_W = 8;
    localparam int FP32_MAN_W = 23;
    localparam int FP64_EXP_W = 11;
    localparam int FP64_MAN_W = 52;
    localparam logic [FP64_EXP_W-1:0] EXP_REBIAS = 11'd769;

    typedef logic [63:0] fmul_res_t;

    // Single operands to double-format product; no normalisation or rounding.
    function automatic fmul_res_t fmulCompute(input logic [31:0] a, input logic [31:0] b);
        fmul_res_t result;
        logic [2*FP32_MAN_W+1:0] prod;
        logic [FP64_EXP_W-1:0] exp11;
        logic sign;
        result = '0;
        prod = 48'({1'b1, a[FP32_MAN_W-1:0]}) * 48'({1'b1, b[FP32_MAN_W-1:0]});
        exp11 = FP64_EXP_W'(a[30:FP32_MAN_W]) + FP64_EXP_W'(b[30:FP32_MAN_W]) + EXP_REBIAS;
        sign = a[31] ^ b[31];
        if (a[30:0] != 31'd0 && b[30:0] != 31'd0) begin
            result = {sign, exp11, prod[45:0], 6'b0};
        end
        return result;
    endfunction

endpackage

// File: rtl/fmul_pipe.sv
// rtl/fmul_pipe.sv - multiplier datapath with LATENCY-stage data/id/valid shift registers
module fmul_pipe
    import fmul_pkg::*;
#(
    parameter int LATENCY = 2,
    parameter int ID_W    = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            inValid,
    input  logic [31:0]     inA,
    input  logic [31:0]     inB,
    input  logic [ID_W-1:0] inId,
    output logic            outValid,
    output fmul_res_t       outData,
    output logic [ID_W-1:0] outId
);

    logic [LATENCY-1:0] stValid;
    fmul_res_t          stData [LATENCY];
    logic [ID_W-1:0]    stId   [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stValid <= '0;
        end else begin
            stValid[0] <= inValid;
            for (int i = 1; i < LATENCY; i++) begin
                stValid[i] <= stValid[i-1];
            end
        end
    end

    // Payload is qualified by stValid everywhere, so it needs no reset.
    always_ff @(posedge clk) begin
        stData[0] <= fmulCompute(inA, inB);
        stId[0]   <= inId;
        for (int i = 1; i < LATENCY; i++) begin
            stData[i] <= stData[i-1];
            stId[i]   <= stId[i-1];
        end
    end

    assign outValid = stValid[LATENCY-1];
    assign outData  = stData[LATENCY-1];
    assign outId    = stId[LATENCY-1];

endmodule

// File: rtl/fmul_rr_scheduler.sv
// rtl/fmul_rr_scheduler.sv - round-robin sharing of one fmul pipe with credit-protected result FIFO
// Optional statistics outputs enabled by FMUL_RR_SCHEDULER_STATS_EN.
module fmul_rr_scheduler
    import fmul_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [32*NUM_REQ-1:0]        req_a,
    input  logic [32*NUM_REQ-1:0]        req_b,
    output logic                         res_valid,
    input  logic                         res_ready,
    output logic [63:0]                  res_data,
    output logic [$clog2(NUM_REQ)-1:0]   res_id,
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    output logic [16*NUM_REQ-1:0]        grant_cnt,
    output logic [15:0]                  stall_cyc,
`endif
    output logic                         busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [ID_W-1:0]  rrPtr;
    logic [ID_W-1:0]  grantIdx;
    logic             grantFound;
    logic             credit;
    logic             issue;
    logic [CNT_W-1:0] inflight;
    logic [CNT_W-1:0] fifoCount;
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    fmul_res_t        fifoData [FIFO_DEPTH];
    logic [ID_W-1:0]  fifoId   [FIFO_DEPTH];
    logic             pipeValid;
    fmul_res_t        pipeData;
    logic [ID_W-1:0]  pipeId;
    logic             fifoRd;
    int               idx;

    // Outstanding work is bounded by FIFO space, so the FIFO can always absorb the pipe.
    assign credit = rst_n &&
        (({1'b0, inflight} + {1'b0, fifoCount}) < (CNT_W+1)'(FIFO_DEPTH));

    always_comb begin
        grantFound = 1'b0;
        grantIdx   = '0;
        idx        = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rrPtr) + k) % NUM_REQ;
            if (!grantFound && req_valid[idx]) begin
                grantFound = 1'b1;
                grantIdx   = ID_W'(idx);
            end
        end
    end

    assign issue = credit & grantFound;

    always_comb begin
        req_ready = '0;
        if (issue) begin
            req_ready[grantIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrPtr <= '0;
        end else if (issue) begin
            rrPtr <= (grantIdx == ID_W'(NUM_REQ - 1)) ? '0 : grantIdx + ID_W'(1);
        end
    end

    fmul_pipe #(
        .LATENCY (LATENCY),
        .ID_W    (ID_W)
    ) uPipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (issue),
        .inA      (req_a[32*grantIdx +: 32]),
        .inB      (req_b[32*grantIdx +: 32]),
        .inId     (grantIdx),
        .outValid (pipeValid),
        .outData  (pipeData),
        .outId    (pipeId)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= '0;
        end else if (issue && !pipeValid) begin
            inflight <= inflight + CNT_W'(1);
        end else if (!issue && pipeValid) begin
            inflight <= inflight - CNT_W'(1);
        end
    end

    assign res_valid = (fifoCount != '0);
    assign fifoRd    = res_valid & res_ready;
    assign res_data  = res_valid ? fifoData[rdPtr] : '0;
    assign res_id    = res_valid ? fifoId[rdPtr] : '0;
    assign busy      = (inflight != '0) | (fifoCount != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr     <= '0;
            rdPtr     <= '0;
            fifoCount <= '0;
        end else begin
            if (pipeValid) begin
                wrPtr <= (wrPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr + PTR_W'(1);
            end
            if (fifoRd) begin
                rdPtr <= (rdPtr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr + PTR_W'(1);
            end
            if (pipeValid && !fifoRd) begin
                fifoCount <= fifoCount + CNT_W'(1);
            end else if (!pipeValid && fifoRd) begin
                fifoCount <= fifoCount - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (pipeValid) begin
            fifoData[wrPtr] <= pipeData;
            fifoId[wrPtr]   <= pipeId;
        end
    end

`ifdef FMUL_RR_SCHEDULER_STATS_EN
    logic [15:0] grantCntR [NUM_REQ];
    logic [15:0] stallCycR;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                grantCntR[i] <= '0;
            end
            stallCycR <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_valid[i] && req_ready[i] && grantCntR[i] != 16'hFFFF) begin
                    grantCntR[i] <= grantCntR[i] + 16'd1;
                end
            end
            if ((|req_valid) && !credit && stallCycR != 16'hFFFF) begin
                stallCycR <= stallCycR + 16'd1;
            end
        end
    end

    always_comb begin
        grant_cnt = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            grant_cnt[16*i +: 16] = grantCntR[i];
        end
    end

    assign stall_cyc = stallCycR;
`endif

endmodule

// File: tb/tb_fmul_rr_scheduler.sv
// tb/tb_fmul_rr_scheduler.sv - directed self-checking bench for fmul_rr_scheduler
module tb_fmul_rr_scheduler;

    localparam int NUM_REQ    = 4;
    localparam int LATENCY    = 2;
    localparam int FIFO_DEPTH = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [NUM_REQ-1:0]     req_valid;
    logic [NUM_REQ-1:0]     req_ready;
    logic [32*NUM_REQ-1:0]  req_a;
    logic [32*NUM_REQ-1:0]  req_b;
    logic                   res_valid;
    logic                   res_ready;
    logic [63:0]            res_data;
    logic [1:0]             res_id;
    logic                   busy;
`ifdef FMUL_RR_SCHEDULER_STATS_EN
    logic [16*NUM_REQ-1:0]  grant_cnt;
    logic [15:0]            stall_cyc;
`endif

    int compared = 0;
    int mismatched = 0;

    fmul_rr_scheduler #(
        .NUM_REQ    (NUM_REQ),
        .LATENCY    (LATENCY),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_id    (res_id),
`ifdef FMUL_RR_SCHEDULER_STATS_EN
        .grant_cnt (grant_cnt),
        .stall_cyc (stall_cyc),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic doReset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Requester i gets 1.0 * 2^(1+i): product exponent 1024+i, zero mantissa.
    task automatic loadPowers();
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[32*i +: 32] = 32'h3F800000;
            req_b[32*i +: 32] = 32'h40000000 + (i << 23);
        end
    endtask

    task automatic runOp(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] expData, input string name);
        int c;
        logic [NUM_REQ-1:0] expReady;
        expReady = '0;
        expReady[id] = 1'b1;
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid = expReady;
        res_ready = 1'b1;
        #1;
        compared++;
        if (req_ready !== expReady) begin
            mismatched++;
            $display("FAIL %s ready: got %b want %b", name, req_ready, expReady);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        #1;
        c = 1;
        while (res_valid !== 1'b1 && c < 20) begin
            @(negedge clk);
            #1;
            c++;
        end
        compared++;
        if (c != LATENCY + 1) begin
            mismatched++;
            $display("FAIL %s latency: got %0d want %0d", name, c, LATENCY + 1);
        end
        compared++;
        if (res_data !== expData || res_id !== 2'(id)) begin
            mismatched++;
            $display("FAIL %s result: got %h id %0d want %h id %0d", name, res_data, res_id, expData, id);
        end
        @(negedge clk);
        #1;
        compared++;
        if (res_valid !== 1'b0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL %s drain: got valid %b busy %b want 0 0", name, res_valid, busy);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        #1;
        compared++;
        if (req_ready !== 4'b0 || res_valid !== 1'b0 || res_data !== 64'h0 ||
            res_id !== 2'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL reset outputs: got ready %b valid %b data %h id %0d busy %b want all 0",
                     req_ready, res_valid, res_data, res_id, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_arith();
        runOp(0, 32'h3F800000, 32'h3F800000, 64'h3FF0000000000000, "one_x_one");
        runOp(1, 32'h40000000, 32'h40400000, 64'h4018000000000000, "two_x_three");
        runOp(2, 32'h3FC00000, 32'h3FC00000, 64'h3FF4000000000000, "unnormalised");
    endtask

    task automatic test_zero();
        runOp(3, 32'h80000000, 32'h40400000, 64'h0, "neg_zero_a");
        runOp(0, 32'h40000000, 32'h00000000, 64'h0, "zero_b");
        runOp(1, 32'hC0000000, 32'h40000000, 64'hC010000000000000, "neg_sign");
    endtask

    task automatic test_round_robin();
        int rx;
        logic [NUM_REQ-1:0] expReady;
        logic [63:0] expData;
        doReset();
        loadPowers();
        res_ready = 1'b1;
        req_valid = '1;
        rx = 0;
        for (int n = 0; n < 40 && rx < 8; n++) begin
            if (n == 8) req_valid = '0;
            #1;
            if (n < 8) begin
                expReady = 4'b0001 << (n % 4);
                compared++;
                if (req_ready !== expReady) begin
                    mismatched++;
                    $display("FAIL rr_grant[%0d]: got %b want %b", n, req_ready, expReady);
                end
            end
            if (res_valid === 1'b1) begin
                expData = {1'b0, 11'(1024 + rx % 4), 52'd0};
                compared++;
                if (res_id !== 2'(rx % 4) || res_data !== expData) begin
                    mismatched++;
                    $display("FAIL rr_result[%0d]: got id %0d data %h want id %0d data %h",
                             rx, res_id, res_data, rx % 4, expData);
                end
                rx++;
            end
            @(negedge clk);
        end
        compared++;
        if (rx != 8) begin
            mismatched++;
            $display("FAIL rr_count: got %0d want 8", rx);
        end
    endtask

    task automatic test_back_to_back_backpressure();
        int g;
        int rx;
        logic [63:0] expData;
        doReset();
        loadPowers();
        res_ready = 1'b0;
        req_valid = '1;
        g = 0;
        for (int n = 0; n < 10; n++) begin
            #1;
            if (req_ready !== 4'b0) begin
                compared++;
                if (req_ready !== (4'b0001 << (g % 4))) begin
                    mismatched++;
                    $display("FAIL bp_grant[%0d]: got %b want %b", g, req_ready, 4'b0001 << (g % 4));
                end
                g++;
            end
            @(negedge clk);
        end
        compared++;
        if (g != FIFO_DEPTH) begin
            mismatched++;
            $display("FAIL bp_accepted: got %0d want %0d", g, FIFO_DEPTH);
        end
        #1;
        compared++;
        if (req_ready !== 4'b0 || busy !== 1'b1 || res_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL bp_stalled: got ready %b busy %b valid %b want 0000 1 1", req_ready, busy, res_valid);
        end
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        rx = 0;
        for (int n = 0; n < 20 && rx < 8; n++) begin
            #1;
            if (res_valid === 1'b1) begin
                expData = {1'b0, 11'(1024 + rx % 4), 52'd0};
                compared++;
                if (res_id !== 2'(rx % 4) || res_data !== expData) begin
                    mismatched++;
                    $display("FAIL bp_drain[%0d]: got id %0d data %h want id %0d data %h",
                             rx, res_id, res_data, rx % 4, expData);
                end
                rx++;
            end
            @(negedge clk);
        end
        compared++;
        if (rx != FIFO_DEPTH || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL bp_drain_count: got %0d busy %b want %0d busy 0", rx, busy, FIFO_DEPTH);
        end
    endtask

    task automatic test_reset_midflight();
        int rx;
        doReset();
        loadPowers();
        res_ready = 1'b0;
        req_valid = '1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        compared++;
        if (busy !== 1'b1 || res_valid !== 1'b1) begin
            mismatched++;
            $display("FAIL mid_preload: got busy %b valid %b want 1 1", busy, res_valid);
        end
        rst_n = 1'b0;
        #1;
        compared++;
        if (req_ready !== 4'b0 || res_valid !== 1'b0 || res_data !== 64'h0 ||
            res_id !== 2'd0 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL mid_reset_outputs: got ready %b valid %b data %h id %0d busy %b want all 0",
                     req_ready, res_valid, res_data, res_id, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        compared++;
        if (req_ready !== 4'b0001) begin
            mismatched++;
            $display("FAIL mid_first_grant: got %b want 0001", req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        res_ready = 1'b1;
        rx = 0;
        for (int n = 0; n < 12; n++) begin
            #1;
            if (res_valid === 1'b1) begin
                compared++;
                if (res_id !== 2'd0 || res_data !== 64'h4000000000000000) begin
                    mismatched++;
                    $display("FAIL mid_result: got id %0d data %h want id 0 data 4000000000000000",
                             res_id, res_data);
                end
                rx++;
            end
            @(negedge clk);
        end
        compared++;
        if (rx != 1) begin
            mismatched++;
            $display("FAIL mid_result_count: got %0d want 1", rx);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        res_ready = 1'b0;
        req_a = '0;
        req_b = '0;
        test_reset();
        test_arith();
        test_zero();
        test_round_robin();
        test_back_to_back_backpressure();
        test_reset_midflight();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
